// File: rtl/lc3_mem_io_bridge_pkg.sv
// Shared types and constants for the LC-3 memory / I/O bridge.
// State encoding plus the default I/O word address.
package lc3_mem_pkg;

  localparam int SRAM_AW = 20;
  localparam int CNT_W = 2;
  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_e;

endpackage

// File: rtl/lc3_mem_io_bridge_if.sv
// CPU-side request bus and SRAM pin bundle for the LC-3 bridge.
// The CPU is master of the request bus; the bridge is master of the SRAM.
interface lc3_cpu_bus_if;

  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR_Out;
  logic        Mem_R;
  logic [15:0] Data_to_CPU;

  modport master (
    output Mem_CE, Mem_OE, Mem_WE, MAR, MDR_Out,
    input  Mem_R, Data_to_CPU
  );

  modport slave (
    input  Mem_CE, Mem_OE, Mem_WE, MAR, MDR_Out,
    output Mem_R, Data_to_CPU
  );

endinterface

interface lc3_sram_if;
  import lc3_mem_pkg::*;

  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [15:0]        SRAM_Din;
  logic [15:0]        SRAM_Dout;
  logic               SRAM_Dout_En;
  logic               SRAM_CE_N;
  logic               SRAM_OE_N;
  logic               SRAM_WE_N;
  logic               SRAM_UB_N;
  logic               SRAM_LB_N;

  modport master (
    output SRAM_ADDR, SRAM_Dout, SRAM_Dout_En,
    output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
    output SRAM_UB_N, SRAM_LB_N,
    input  SRAM_Din
  );

  modport slave (
    input  SRAM_ADDR, SRAM_Dout, SRAM_Dout_En,
    input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
    input  SRAM_UB_N, SRAM_LB_N,
    output SRAM_Din
  );

endinterface

// File: rtl/lc3_mem_io_bridge.sv
// LC-3 memory bridge: level strobes to timed async-SRAM cycles,
// plus the memory-mapped switch/hex I/O word and a Mem_R ready flag.
module lc3_mem_io_bridge
  import lc3_mem_pkg::*;
#(
  parameter int          READ_WAIT = 2,
  parameter int          WR_PULSE  = 2,
  parameter logic [15:0] IO_ADDR   = IO_ADDR_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  lc3_cpu_bus_if.slave  cpu,
  lc3_sram_if.master    sram,
  input  logic [15:0]   Switches,
  output logic [15:0]   HEX_Out
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       hex_q, hex_d;
  logic              mem_r_q, mem_r_d;
  logic              bus_n_q, bus_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dout_en_q, dout_en_d;

  logic rd_req;
  logic wr_req;
  logic is_io;

  // Read wins when both strobes are low.
  assign rd_req = !cpu.Mem_CE && !cpu.Mem_OE;
  assign wr_req = !cpu.Mem_CE && !cpu.Mem_WE && cpu.Mem_OE;
  assign is_io  = (cpu.MAR == IO_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          if (is_io) begin
            rdata_d = Switches;
            state_d = S_DONE;
          end else begin
            addr_d  = cpu.MAR;
            state_d = S_RD_WAIT;
          end
        end else if (wr_req) begin
          if (is_io) begin
            hex_d   = cpu.MDR_Out;
            state_d = S_DONE;
          end else begin
            addr_d  = cpu.MAR;
            wdata_d = cpu.MDR_Out;
            state_d = S_WR_SETUP;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = sram.SRAM_Din;
          state_d = S_DONE;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE: begin
        if (cpu.Mem_OE && cpu.Mem_WE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Pin values are decoded from the next state so they
  // come straight out of flops in the cycle they apply to.
  always_comb begin
    mem_r_d   = (state_d == S_DONE);
    oe_n_d    = (state_d != S_RD_WAIT);
    we_n_d    = (state_d != S_WR_PULSE);
    dout_en_d = (state_d == S_WR_SETUP) ||
                (state_d == S_WR_PULSE) ||
                (state_d == S_WR_HOLD);
    bus_n_d   = !(dout_en_d || (state_d == S_RD_WAIT));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hex_q     <= '0;
      mem_r_q   <= 1'b0;
      bus_n_q   <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dout_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      mem_r_q   <= mem_r_d;
      bus_n_q   <= bus_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign cpu.Mem_R        = mem_r_q;
  assign cpu.Data_to_CPU  = rdata_q;
  assign HEX_Out          = hex_q;
  assign sram.SRAM_ADDR   = {{(SRAM_AW-16){1'b0}}, addr_q};
  assign sram.SRAM_Dout   = wdata_q;
  assign sram.SRAM_Dout_En = dout_en_q;
  assign sram.SRAM_CE_N   = bus_n_q;
  assign sram.SRAM_UB_N   = bus_n_q;
  assign sram.SRAM_LB_N   = bus_n_q;
  assign sram.SRAM_OE_N   = oe_n_q;
  assign sram.SRAM_WE_N   = we_n_q;

endmodule

// File: doc/lc3_mem_io_bridge.md
Name: lc3_mem_io_bridge

Overview:
- Sits between the LC-3 control unit / datapath (MAR, MDR, active-low Mem_* strobes) and the external 16-bit asynchronous SRAM.
- Turns level-held read/write strobes into properly timed SRAM cycles.
- Decodes the memory-mapped I/O word (switches in, hex display out).
- Returns a ready flag (Mem_R) so the control unit waits on completion instead of counting a fixed number of cycles.

Parameters:
READ_WAIT, 2, cycles SRAM_OE_N held low before read data is captured (≥1)
WR_PULSE, 2, cycles SRAM_WE_N held low per write (≥1)
IO_ADDR, 16'hFFFF, address decoded as I/O (read = switches, write = hex register)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Mem_CE  in  1  active-low chip enable from control unit; high means requests are ignored
Mem_OE  in  1  active-low read request, level, held until Mem_R
Mem_WE  in  1  active-low write request, level, held until Mem_R
MAR  in  16  word address
MDR_Out  in  16  write data from datapath
Switches  in  16  board switches
Mem_R  out  1  operation complete; high only in DONE
Data_to_CPU  out  16  registered read result (to MDR mux)
HEX_Out  out  16  hex-display register
SRAM_ADDR  out  20  SRAM address, {4'b0, MAR}
SRAM_Din  in  16  data from SRAM pins
SRAM_Dout  out  16  data to SRAM pins
SRAM_Dout_En  out  1  tristate enable for SRAM_Dout (pad tristate lives in top level)
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active low

Behaviour:
- Clocking: all outputs registered. Everything is driven by one clock, Clk; Reset is synchronous and active-high.
- Reset values:
  - Mem_R = 0; Data_to_CPU = 0; HEX_Out = 0.
  - SRAM_ADDR = 0; SRAM_Dout = 0; SRAM_Dout_En = 0.
  - All five SRAM_*_N = 1.
  - State = IDLE.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Request capture:
  - In IDLE with Mem_CE = 0:
    - Mem_OE = 0 → read.
    - Mem_WE = 0 → write.
    - Both low → read; the write is ignored.
  - On the accept edge (cycle t), MAR and MDR_Out are latched internally.
  - Strobe, MAR and MDR changes after acceptance are ignored until DONE.
- I/O decode (latched MAR == IO_ADDR; no SRAM activity at all):
  - Read: Data_to_CPU ← Switches at edge t; state DONE from t+1.
  - Write: HEX_Out ← latched MDR at edge t; state DONE from t+1.
- SRAM read:
  - RD_WAIT lasts READ_WAIT cycles (t+1 .. t+READ_WAIT), with SRAM_CE_N, OE_N, UB_N, LB_N = 0.
  - At the end of the last RD_WAIT cycle, Data_to_CPU ← SRAM_Din.
  - DONE from t+READ_WAIT+1.
- SRAM write:
  - Signals valid throughout WR_SETUP..WR_HOLD: SRAM_CE_N = UB_N = LB_N = 0; SRAM_Dout_En = 1; SRAM_Dout = latched data.
  - WR_SETUP: 1 cycle at t+1; SRAM_WE_N = 1.
  - WR_PULSE: WR_PULSE cycles; SRAM_WE_N = 0.
  - WR_HOLD: 1 cycle; SRAM_WE_N = 1.
  - DONE from t+WR_PULSE+3.
  - Address and data are stable from one cycle before the WE_N falling edge to one cycle after its rising edge.
  - SRAM_Dout_En is never 1 while SRAM_OE_N = 0.
- DONE:
  - Mem_R = 1; all SRAM strobes = 1; Dout_En = 0.
  - Remains while Mem_OE = 0 or Mem_WE = 0.
  - When both are high, next state is IDLE and Mem_R = 0.
  - A held strobe never retriggers; a strobe released early still yields at least one Mem_R cycle.
- Data_to_CPU holds its value until the next read completes. Writes do not change it.
- Reset mid-operation: the next edge restores reset values, so SRAM strobes deassert within one cycle. No partial HEX_Out update. Any SRAM write in progress is abandoned.
- Counter: 2-bit phase counter (sized to max(READ_WAIT, WR_PULSE)), cleared on every state entry.

Decomposition:
- Package lc3_mem_pkg holds:
  - the state enum;
  - the IO_ADDR default;
  - a localparam for the SRAM address width (20).
- No sub-module. The counter and FSM stay in the single module; the pad tristate stays in the top level.

Test Plan:
1. SRAM[0x0003] = 0x1234; hold Mem_OE = 0, MAR = 0x0003 from cycle 0.
   → SRAM_OE_N low for cycles 1–2; Data_to_CPU = 0x1234 and Mem_R = 1 at cycle 3.
   → Release strobe: Mem_R = 0 one cycle after release.
2. Mem_WE = 0, MAR = 0x0010, MDR = 0xA5A5.
   → SRAM_WE_N low for exactly cycles 2–3; Dout_En high for cycles 1–4; Mem_R at cycle 5; SRAM[0x0010] = 0xA5A5.
3. Switches = 0xBEEF; read at MAR = 0xFFFF.
   → Mem_R at cycle 1; Data_to_CPU = 0xBEEF; SRAM_CE_N stays 1 throughout.
4. Write 0x00AB to 0xFFFF.
   → HEX_Out = 0x00AB at cycle 1; no SRAM strobe activity; SRAM unchanged.
5. Assert Reset during WR_PULSE.
   → Next cycle: SRAM_WE_N = 1, Dout_En = 0, Mem_R = 0, state IDLE; HEX_Out unchanged from reset value.
6. Mem_OE = Mem_WE = 0 simultaneously, held for 10 cycles.
   → Exactly one read occurs; no WE_N pulse; Mem_R stays high until both strobes are released; no second access.
